// File: rtl/registers_bank_if.sv
// Register bank bus: two combinational read ports and one write port.
//
// Handshake: this bus has no valid/ready pair. 'write' is a plain qualifier
// sampled on every rising clock edge; when it is high, 'data' is stored at
// 'addr_d' on that edge. The read ports 'a'/'b' are combinational and always
// reflect the current contents at 'addr_a'/'addr_b'.
interface registers_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data;
  logic                  write;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;

  // Requester side: drives addresses and write data, observes read data.
  modport master (
    output addr_a, addr_b, addr_d, data, write,
    input  a, b
  );

  // Register bank side.
  modport slave (
    input  addr_a, addr_b, addr_d, data, write,
    output a, b
  );
endinterface

// File: rtl/registers_bank.sv
// General-purpose register bank: NUM_REGS x DATA_WIDTH, two asynchronous
// read ports, one synchronous write port. Register 0 is ordinary storage.
// A write becomes visible on the read ports only after the writing edge;
// there is no write-to-read bypass.
module registers_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  registers_bank_if.slave       bus
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;

  // Storage update: reset clears every register and wins over a
  // simultaneous write; otherwise only the addressed register is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.write) begin
      r_regs[bus.addr_d] <= bus.data;
    end
  end

  // Combinational read ports, independent of each other and of the write port.
  always_comb begin
    w_a = r_regs[bus.addr_a];
    w_b = r_regs[bus.addr_b];
  end

  assign bus.a = w_a;
  assign bus.b = w_b;

endmodule

// File: tb/tb_registers_bank.sv
// Directed self-checking bench for registers_bank.
module tb_registers_bank;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk;
  logic reset;

  int n_tests;
  int n_fail;

  logic [DW-1:0] model [NR];

  registers_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  registers_bank #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_read(input int ra, input int rb);
    bus.addr_a = AW'(ra);
    bus.addr_b = AW'(rb);
    #1;
  endtask

  task automatic set_write(input logic we, input int rd, input logic [DW-1:0] wd);
    bus.write  = we;
    bus.addr_d = AW'(rd);
    bus.data   = wd;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    set_write(1'b0, 0, '0);
    set_read(0, 0);

    // Reset for one edge, then sweep every address on both ports.
    tick();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) begin
      set_read(i, NR - 1 - i);
      check($sformatf("reset_a[%0d]", i), bus.a, 32'h0);
      check($sformatf("reset_b[%0d]", NR - 1 - i), bus.b, 32'h0);
    end

    // Write reg0 = 1 while reading regs 1 and 2.
    set_write(1'b1, 0, 32'h0000_0001);
    set_read(1, 2);
    check("w0_pre_a", bus.a, 32'h0);
    check("w0_pre_b", bus.b, 32'h0);
    tick();
    set_write(1'b0, 0, '0);
    set_read(1, 2);
    check("w0_reg1", bus.a, 32'h0);
    check("w0_reg2", bus.b, 32'h0);
    set_read(0, 0);
    check("w0_a", bus.a, 32'h0000_0001);
    check("w0_b", bus.b, 32'h0000_0001);

    // write=0 must not change reg0.
    set_write(1'b0, 0, 32'h0000_0003);
    tick();
    set_read(0, 0);
    check("nowrite_reg0", bus.a, 32'h0000_0001);

    // No bypass: read of addr_d shows old value until the edge.
    set_write(1'b1, 1, 32'h0000_0002);
    set_read(1, 0);
    check("nobypass_pre_a", bus.a, 32'h0);
    check("nobypass_pre_b", bus.b, 32'h0000_0001);
    tick();
    set_write(1'b0, 1, '0);
    set_read(1, 0);
    check("nobypass_post_a", bus.a, 32'h0000_0002);
    check("nobypass_post_b", bus.b, 32'h0000_0001);

    // Reset has priority over a same-edge write.
    reset = 1'b1;
    set_write(1'b1, 31, 32'hFFFF_FFFF);
    tick();
    reset = 1'b0;
    set_write(1'b0, 31, '0);
    set_read(31, 0);
    check("rst_prio_r31", bus.a, 32'h0);
    check("rst_prio_r0", bus.b, 32'h0);
    set_read(1, 1);
    check("rst_prio_r1", bus.a, 32'h0);

    // Same write without reset lands on both ports.
    set_write(1'b1, 31, 32'hFFFF_FFFF);
    tick();
    set_write(1'b0, 0, '0);
    set_read(31, 31);
    check("w31_a", bus.a, 32'hFFFF_FFFF);
    check("w31_b", bus.b, 32'hFFFF_FFFF);

    // Reset raised mid-operation: contents visible until the edge.
    reset = 1'b1;
    #1;
    check("rst_mid_pre_a", bus.a, 32'hFFFF_FFFF);
    check("rst_mid_pre_b", bus.b, 32'hFFFF_FFFF);
    tick();
    reset = 1'b0;
    set_read(31, 31);
    check("rst_mid_post_a", bus.a, 32'h0);
    check("rst_mid_post_b", bus.b, 32'h0);

    // Fill every register with a distinct value.
    for (int i = 0; i < NR; i++) begin
      model[i] = {8'hC3, 8'(i), 16'(i * 16'h1357 + 16'h00A5)};
      set_write(1'b1, i, model[i]);
      tick();
    end
    set_write(1'b0, 0, '0);

    // Directed corners: register 0 and last register on both ports.
    set_read(0, NR - 1);
    check("fill_r0", bus.a, {8'hC3, 8'h00, 16'h00A5});
    check("fill_r31", bus.b, {8'hC3, 8'h1F, 16'(31 * 16'h1357 + 16'h00A5)});

    // Random read pairs against the fill model.
    for (int k = 0; k < 40; k++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(0, NR - 1));
      rb = int'($urandom_range(0, NR - 1));
      set_read(ra, rb);
      check($sformatf("rand_a[%0d]", ra), bus.a, model[ra]);
      check($sformatf("rand_b[%0d]", rb), bus.b, model[rb]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is short; stop if it ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/registers_bank.md
REGISTERS_BANK -- requirements
Module: registers_bank

Interface
REQ-001: The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002: Parameter DATA_WIDTH, default 32, width of each register and of the data/read ports.
REQ-003: Parameter ADDR_WIDTH, default 5, width of each address port.
REQ-004: Parameter NUM_REGS, default 32 (2**ADDR_WIDTH), number of registers.
REQ-005: clk  input  1  clock; all state changes on its rising edge.
REQ-006: reset  input  1  synchronous active-high reset.
REQ-007: addr_a  input  ADDR_WIDTH  read address for port A.
REQ-008: addr_b  input  ADDR_WIDTH  read address for port B.
REQ-009: addr_d  input  ADDR_WIDTH  write (destination) address.
REQ-010: data  input  DATA_WIDTH  write data.
REQ-011: write  input  1  write enable, active-high.
REQ-012: a  output  DATA_WIDTH  contents of register addr_a.
REQ-013: b  output  DATA_WIDTH  contents of register addr_b.

Function
REQ-014: The block SHALL hold NUM_REGS general registers of DATA_WIDTH bits, indexed 0..NUM_REGS-1.
REQ-015: Register 0 SHALL be an ordinary writable register; it is not hardwired to zero.
REQ-016: Reads SHALL be combinational: a = reg[addr_a] and b = reg[addr_b] with no clock latency, and SHALL update within the same cycle as any address change.
REQ-017: Both read ports SHALL be independent and may address the same register, each other, or addr_d simultaneously.
REQ-018: On a rising clk edge with reset=0 and write=1, reg[addr_d] SHALL take the value of data; all other registers SHALL be unchanged.
REQ-019: With write=0, no register SHALL change, regardless of addr_d and data.
REQ-020: Write latency SHALL be one edge: the new value appears on a/b immediately after the writing edge, with no bypass. A read of addr_d during the write cycle SHALL return the old value until the edge.
REQ-021: Address values are always in range, since NUM_REGS=2**ADDR_WIDTH. No wrap-around or error handling is required.

Reset
REQ-022: On a rising clk edge with reset=1, all registers SHALL be cleared to 0, so a=b=0 for every address afterwards.
REQ-023: Reset SHALL take priority over write; a write on the same edge as reset SHALL be discarded.
REQ-024: Reset asserted mid-operation SHALL affect state only at the next rising edge. Before that edge, outputs keep showing the current contents.
REQ-025: Register contents before the first reset are undefined and SHALL NOT be relied on.

Verification
REQ-026: Reset for one edge, then sweep addr_a/addr_b over 0..31 -> a=b=0x00000000 everywhere.
REQ-027: write=1, addr_d=0, data=0x00000001, addr_a=1, addr_b=2, one edge; then addr_a=addr_b=0 -> a=b=0x00000001, and regs 1 and 2 still read 0.
REQ-028: write=0, addr_d=0, data=0x00000003, one edge -> reg0 still reads 0x00000001.
REQ-029: addr_a=1, addr_b=0, addr_d=1, data=0x00000002, write=1 -> a=0x00000000 before the edge and 0x00000002 after it; b=0x00000001 throughout.
REQ-030: reset=1 and write=1 to addr_d=31 with data=0xFFFFFFFF on the same edge -> reg31 reads 0x00000000. The same write with reset=0 -> 0xFFFFFFFF on both ports when addr_a=addr_b=31.
REQ-031: Write distinct values to all 32 registers, then read random pairs -> each port returns exactly the value written to its address.
